// File: rtl/div_seq_ctrl_if.sv
// Command and comparator signal bundle for the sequential divider controller.
// The master side issues requests and hosts the comparator; the slave side is the controller.
interface div_seq_ctrl_if;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        cmp_enable;
  logic [15:0] cmp_a;
  logic [15:0] cmp_b;
  logic        cmp_gt;

  modport master (
    output start, dividend, divisor, cmp_gt,
    input  busy, done, quotient, remainder, div_by_zero, cmp_enable, cmp_a, cmp_b
  );

  modport slave (
    input  start, dividend, divisor, cmp_gt,
    output busy, done, quotient, remainder, div_by_zero, cmp_enable, cmp_a, cmp_b
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for a 16-bit unsigned restoring divider: one SHIFT and one CMP cycle per quotient bit,
// using an external combinational greater-than comparator for the trial subtraction decision.
module div_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  div_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CMP,
    S_DONE,
    S_DONE_Z
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH:0]     r_p;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic               r_dbz;
  logic               w_accept;
  logic               w_zeroDiv;
  logic               w_sub;
  logic               w_lastIter;
  logic [WIDTH:0]     w_pDiff;

  assign w_zeroDiv  = (bus.divisor == '0);
  assign w_pDiff    = r_p - {1'b0, r_d};
  // An overflowed partial remainder always exceeds D, so subtract regardless of the comparator.
  assign w_sub      = r_p[WIDTH] || !bus.cmp_gt;
  assign w_lastIter = (r_cnt == CNT_W'(1));

  assign bus.cmp_a       = r_d;
  assign bus.cmp_b       = r_p[WIDTH-1:0];
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    bus.busy       = (r_state != S_IDLE);
    bus.done       = 1'b0;
    bus.cmp_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = w_zeroDiv ? S_DONE_Z : S_SHIFT;
        end
      end
      S_SHIFT: w_next = S_CMP;
      S_CMP: begin
        bus.cmp_enable = 1'b1;
        w_next         = w_lastIter ? S_DONE : S_SHIFT;
      end
      S_DONE, S_DONE_Z: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Result registers are loaded on the edge entering DONE/DONE_Z so they are valid with done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_p    <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_d   <= bus.divisor;
            r_q   <= bus.dividend;
            r_p   <= '0;
            r_cnt <= CNT_W'(WIDTH);
            r_dbz <= w_zeroDiv;
            if (w_zeroDiv) begin
              r_quot <= '1;
              r_rem  <= bus.dividend;
            end
          end
        end
        S_SHIFT: begin
          r_p <= {r_p[WIDTH-1:0], r_q[WIDTH-1]};
          r_q <= {r_q[WIDTH-2:0], 1'b0};
        end
        S_CMP: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_sub) begin
            r_p    <= w_pDiff;
            r_q[0] <= 1'b1;
          end
          if (w_lastIter) begin
            r_quot <= {r_q[WIDTH-1:1], w_sub};
            r_rem  <= w_sub ? w_pDiff[WIDTH-1:0] : r_p[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
